// File: rtl/pattern_shift_tx.sv
// Serial transmitter feeding an external D flip-flop chain: MSB-first data on sd, divided sck,
// lat strobe after each word. Define PATTERN_TX_BUF_EN to add a one-word pending buffer.
module pattern_shift_tx #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 2
) (
   input  logic             C,
   input  logic             Reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sd,
   output logic             sck,
   output logic             lat,
   output logic             busy
);

   localparam int unsigned DW = $clog2(DIV) + 1;
   localparam int unsigned BW = $clog2(WIDTH) + 1;
   localparam logic [DW-1:0] DivLowEnd  = DW'(DIV - 1);
   localparam logic [DW-1:0] DivHighEnd = DW'(2 * DIV - 1);
   localparam logic [BW-1:0] BitFirst   = BW'(WIDTH - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StLatch = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [DW-1:0]    div_q, div_d;
   logic             sck_q, sck_d;
   logic             lat_q, lat_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             hs, load;
   logic [WIDTH-1:0] load_word;

`ifdef PATTERN_TX_BUF_EN
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
`endif

   assign hs = din_valid && ready_q;

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      bit_d     = bit_q;
      div_d     = div_q;
      sck_d     = sck_q;
      lat_d     = lat_q;
      load      = 1'b0;
      load_word = din;
`ifdef PATTERN_TX_BUF_EN
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
`endif
      case (state_q)
         StIdle: begin
            if (hs) load = 1'b1;
         end
         StShift: begin
`ifdef PATTERN_TX_BUF_EN
            if (hs) begin
               buf_d      = din;
               buf_full_d = 1'b1;
            end
`endif
            if (div_q == DivHighEnd) begin
               // Shifting after the last bit leaves zeros, so sd idles low for free.
               div_d = '0;
               sck_d = 1'b0;
               sh_d  = sh_q << 1;
               if (bit_q == '0) begin
                  state_d = StLatch;
                  lat_d   = 1'b1;
               end else begin
                  bit_d = bit_q - BW'(1);
               end
            end else begin
               div_d = div_q + DW'(1);
               if (div_q == DivLowEnd) sck_d = 1'b1;
            end
         end
         StLatch: begin
            if (div_q == DivLowEnd) begin
               lat_d   = 1'b0;
               state_d = StIdle;
`ifdef PATTERN_TX_BUF_EN
               if (buf_full_q) begin
                  load       = 1'b1;
                  load_word  = buf_q;
                  buf_full_d = hs;
                  if (hs) buf_d = din;
               end else if (hs) begin
                  load = 1'b1;
               end
`endif
            end else begin
               div_d = div_q + DW'(1);
`ifdef PATTERN_TX_BUF_EN
               if (hs) begin
                  buf_d      = din;
                  buf_full_d = 1'b1;
               end
`endif
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         sh_d    = load_word;
         bit_d   = BitFirst;
         div_d   = '0;
         sck_d   = 1'b0;
         lat_d   = 1'b0;
         state_d = StShift;
      end

      busy_d = (state_d != StIdle);
`ifdef PATTERN_TX_BUF_EN
      ready_d = !buf_full_d;
`else
      ready_d = (state_d == StIdle);
`endif
   end

   always_ff @(posedge C) begin
      if (Reset) begin
         state_q <= StIdle;
         sh_q    <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         sck_q   <= 1'b0;
         lat_q   <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         sck_q   <= sck_d;
         lat_q   <= lat_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

`ifdef PATTERN_TX_BUF_EN
   always_ff @(posedge C) begin
      if (Reset) begin
         buf_q      <= '0;
         buf_full_q <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
      end
   end
`endif

   assign sd        = sh_q[WIDTH-1];
   assign sck       = sck_q;
   assign lat       = lat_q;
   assign busy      = busy_q;
   assign din_ready = ready_q;

endmodule

// File: tb/tb_pattern_shift_tx.sv
// Scoreboard bench for pattern_shift_tx: accepted words push expected bits and lat times,
// a negedge monitor pops them at each sck / lat rise.
module tb_pattern_shift_tx;

   logic       C = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       din_ready, sd, sck, lat, busy;

   logic [0:0] din1 = '0;
   logic       v1 = 1'b0;
   logic       r1, sd1, sck1, lat1, busy1;

   int total = 0;
   int bad = 0;
   int edge_cnt = 0;
   int last_end = 0;
   int overlap = 0;
   int busy_low = 0;
   logic sck_prev = 1'b0;
   logic lat_prev = 1'b0;
   logic exp_bits[$];
   int   exp_lat[$];

   pattern_shift_tx #(.WIDTH(8), .DIV(2)) u_dut (
      .C(C), .Reset(Reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .sd(sd), .sck(sck), .lat(lat), .busy(busy)
   );

   pattern_shift_tx #(.WIDTH(1), .DIV(1)) u_dut1 (
      .C(C), .Reset(Reset), .din(din1), .din_valid(v1), .din_ready(r1),
      .sd(sd1), .sck(sck1), .lat(lat1), .busy(busy1)
   );

   always #5 C = ~C;
   always @(posedge C) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Monitor: pops expected sd bit at each sck rise and expected edge at each lat rise.
   always @(negedge C) begin
      if (!Reset) begin
         if (sck && !sck_prev) begin
            if (exp_bits.size() == 0) chk("unexpected_sck", 1, 0);
            else chk("sd_at_sck", int'(sd), int'(exp_bits.pop_front()));
         end
         if (lat && !lat_prev) begin
            if (exp_lat.size() == 0) chk("unexpected_lat", 1, 0);
            else chk("lat_time", edge_cnt, exp_lat.pop_front());
         end
         if (!busy) busy_low++;
      end
      if (sck && lat) overlap++;
      sck_prev = sck;
      lat_prev = lat;
   end

   // Call at a negedge; returns at the negedge following the acceptance edge, din_valid held.
   task automatic send(input logic [7:0] w, output int acc);
      int n;
      int start;
      din = w;
      din_valid = 1'b1;
      n = 0;
      while (!din_ready && n < 200) begin
         @(negedge C);
         n++;
      end
      if (!din_ready) begin
         chk("accept_timeout", 0, 1);
         acc = -1;
         return;
      end
      @(negedge C);
      acc = edge_cnt;
      for (int i = 7; i >= 0; i--) exp_bits.push_back(w[i]);
      start = (acc > last_end) ? acc : last_end;
      exp_lat.push_back(start + 32);
      last_end = start + 34;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_bits.size() + exp_lat.size()) != 0 && n < 300) begin
         @(negedge C);
         n++;
      end
      chk("drain", exp_bits.size() + exp_lat.size(), 0);
   endtask

   task automatic wait_edge(input int e);
      int n = 0;
      while (edge_cnt < e && n < 500) begin
         @(negedge C);
         n++;
      end
   endtask

   initial begin
      int a1, a2, cnt;
      // Reset then idle
      repeat (3) begin
         @(negedge C);
         chk("reset_outs", int'({din_ready, sd, sck, lat, busy}), 0);
      end
      Reset = 1'b0;
      @(negedge C);
      chk("ready_after_reset", int'(din_ready), 1);
      chk("ready1_after_reset", int'(r1), 1);
      cnt = 0;
      repeat (20) begin
         @(negedge C);
         if (sck || lat || busy) cnt++;
      end
      chk("idle_quiet", cnt, 0);

      // DIV=1, WIDTH=1 instance
      din1 = 1'b1;
      v1 = 1'b1;
      @(negedge C);
      v1 = 1'b0;
      chk("w1_c1", int'({sd1, sck1, lat1}), 3'b100);
      @(negedge C);
      chk("w1_c2", int'({sd1, sck1, lat1}), 3'b110);
      @(negedge C);
      chk("w1_c3", int'({sd1, sck1, lat1}), 3'b001);
      @(negedge C);
      chk("w1_c4", int'({sd1, sck1, lat1, r1}), 4'b0001);

      // Single word A5
      send(8'hA5, a1);
      din_valid = 1'b0;
      wait_edge(a1 + 1);
      chk("sck_cycle2", int'(sck), 0);
      wait_edge(a1 + 2);
      chk("sck_cycle3", int'(sck), 1);
      wait_edge(a1 + 33);
      chk("busy_cycle34", int'(busy), 1);
      wait_edge(a1 + 34);
      chk("busy_cycle35", int'(busy), 0);
      drain();

      // Back-to-back FF then 00
      send(8'hFF, a1);
      busy_low = 0;
      send(8'h00, a2);
      din_valid = 1'b0;
`ifdef PATTERN_TX_BUF_EN
      chk("b2b_gap", a2 - a1, 1);
      wait_edge(a1 + 34);
      chk("frame2_ready", int'(din_ready), 1);
      chk("frame2_busy", int'(busy), 1);
      wait_edge(a1 + 60);
      chk("idle_between", busy_low, 0);
`else
      chk("b2b_gap", a2 - a1, 35);
      wait_edge(a1 + 60);
      chk("idle_between", busy_low, 1);
`endif
      drain();

      // Reset during bit 3 of 3C, then 81
      send(8'h3C, a1);
      din_valid = 1'b0;
      wait_edge(a1 + 13);
      Reset = 1'b1;
      @(negedge C);
      chk("midreset_outs", int'({din_ready, sd, sck, lat, busy}), 0);
      chk("pre_reset_bits_left", exp_bits.size(), 5);
      exp_bits.delete();
      exp_lat.delete();
      last_end = 0;
      Reset = 1'b0;
      repeat (40) @(negedge C);
      send(8'h81, a1);
      din_valid = 1'b0;
      drain();

      chk("sck_lat_overlap", overlap, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
